// File: rtl/hdmi_frame_wr_ctrl.sv
// Buffers packed HDMI pixel words in a FWFT FIFO and drains them to DDR as fixed-length bursts.
// Define FRAME_PINGPONG_EN to alternate frames between FRAME_BASE0 and FRAME_BASE1.
module hdmi_frame_wr_ctrl #(
    parameter int unsigned       BURST_LEN   = 64,
    parameter int unsigned       FIFO_DEPTH  = 256,
    parameter int unsigned       ADDR_W      = 28,
    parameter logic [23:0]       FRAME_WORDS = 24'd2073600,
    parameter logic [ADDR_W-1:0] FRAME_BASE0 = 28'h0000000,
    parameter logic [ADDR_W-1:0] FRAME_BASE1 = 28'h0800000
) (
    input  logic              hdmi_clk,
    input  logic              sys_rst,
    input  logic              hdmi_vs_in,
    input  logic              hdmi_wr_en,
    input  logic [31:0]       hdmi_data_dw_in,
    output logic              wr_burst_req,
    output logic [ADDR_W-1:0] wr_burst_addr,
    output logic [9:0]        wr_burst_len,
    input  logic              wr_burst_data_req,
    output logic [31:0]       wr_burst_data,
    input  logic              wr_burst_finish,
    output logic [ADDR_W-1:0] rd_frame_base,
    output logic              frame_done,
    output logic              fifo_ovf
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(BURST_LEN) + 1;

    typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

    state_t            state, state_next;
    logic [31:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [CNT_W-1:0]  pop_cnt;
    logic [23:0]       offset;
    logic              vs_d1, vs_rise, frame_pend, frame_full, wr_sel;
    logic              full, push, pop, restart, start_burst;
    logic [ADDR_W-1:0] wr_base;

    assign vs_rise       = hdmi_vs_in & ~vs_d1;
    assign full          = (level == LVL_W'(FIFO_DEPTH));
    assign push          = hdmi_wr_en & ~full;
    // Pops are capped at one burst's worth and never taken from an empty FIFO.
    assign pop           = wr_burst_data_req & ((state == REQ) | (state == DATA))
                         & (pop_cnt < CNT_W'(BURST_LEN)) & (level != '0);
    assign wr_base       = wr_sel ? FRAME_BASE1 : FRAME_BASE0;
    assign wr_burst_req  = (state == REQ);
    assign wr_burst_len  = 10'(BURST_LEN);
    assign wr_burst_data = mem[rd_ptr];

    always_ff @(posedge hdmi_clk) begin
        // NOTE: registers use <= so every flop updates from pre-edge values, independent of block order.
        if (sys_rst) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_next  = state;
        restart     = 1'b0;
        start_burst = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_pend) begin
                    restart = 1'b1;
                end else if (level >= LVL_W'(BURST_LEN)) begin
                    start_burst = 1'b1;
                    state_next  = REQ;
                end
            end
            REQ:     if (wr_burst_data_req) state_next = DATA;
            DATA:    if (wr_burst_finish)   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the storage array has no reset; pointers and level alone define which words are valid.
    always_ff @(posedge hdmi_clk) begin
        if (push) mem[wr_ptr] <= hdmi_data_dw_in;
    end

    always_ff @(posedge hdmi_clk) begin
        if (sys_rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            pop_cnt       <= '0;
            offset        <= '0;
            vs_d1         <= 1'b0;
            frame_pend    <= 1'b0;
            frame_full    <= 1'b0;
            wr_sel        <= 1'b0;
            fifo_ovf      <= 1'b0;
            frame_done    <= 1'b0;
            wr_burst_addr <= FRAME_BASE0;
            rd_frame_base <= FRAME_BASE0;
        end else begin
            vs_d1      <= hdmi_vs_in;
            frame_pend <= vs_rise | (frame_pend & ~restart);
            frame_done <= restart & frame_full;
            if (hdmi_wr_en & full) fifo_ovf <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;

            // A flush keeps only a word accepted in the same cycle: it belongs to the new frame.
            if (restart) begin
                rd_ptr     <= wr_ptr;
                level      <= LVL_W'(push);
                offset     <= '0;
                frame_full <= 1'b0;
                if (frame_full) begin
                    rd_frame_base <= wr_base;
`ifdef FRAME_PINGPONG_EN
                    wr_sel <= ~wr_sel;
`endif
                end
            end else begin
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                level <= level + LVL_W'(push) - LVL_W'(pop);
            end

            if (start_burst) begin
                wr_burst_addr <= wr_base + ADDR_W'({offset, 2'b00});
                pop_cnt       <= '0;
            end else if (pop) begin
                pop_cnt <= pop_cnt + 1'b1;
            end

            if (state == DONE) begin
                if (offset + 24'(BURST_LEN) == FRAME_WORDS) begin
                    offset     <= '0;
                    frame_full <= 1'b1;
                end else begin
                    offset <= offset + 24'(BURST_LEN);
                end
            end
        end
    end

endmodule

// File: tb/tb_hdmi_frame_wr_ctrl.sv
// Self-checking bench for hdmi_frame_wr_ctrl: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a queue-based behavioural model.
module tb_hdmi_frame_wr_ctrl;

    localparam int unsigned BURST = 64;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned FRAME = 128;
    localparam logic [27:0] BASE0 = 28'h0000000;
    localparam logic [27:0] BASE1 = 28'h0800000;
`ifdef FRAME_PINGPONG_EN
    localparam logic [27:0] SWAP_BASE = BASE1;
`else
    localparam logic [27:0] SWAP_BASE = BASE0;
`endif

    logic        hdmi_clk = 1'b0;
    logic        sys_rst, hdmi_vs_in, hdmi_wr_en;
    logic [31:0] hdmi_data_dw_in;
    logic        wr_burst_req, wr_burst_data_req, wr_burst_finish;
    logic [27:0] wr_burst_addr, rd_frame_base;
    logic [9:0]  wr_burst_len;
    logic [31:0] wr_burst_data;
    logic        frame_done, fifo_ovf;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit cmp_en = 1'b0;

    hdmi_frame_wr_ctrl #(
        .BURST_LEN(BURST), .FIFO_DEPTH(DEPTH), .ADDR_W(28), .FRAME_WORDS(24'(FRAME)),
        .FRAME_BASE0(BASE0), .FRAME_BASE1(BASE1)
    ) dut (
        .hdmi_clk(hdmi_clk), .sys_rst(sys_rst), .hdmi_vs_in(hdmi_vs_in),
        .hdmi_wr_en(hdmi_wr_en), .hdmi_data_dw_in(hdmi_data_dw_in),
        .wr_burst_req(wr_burst_req), .wr_burst_addr(wr_burst_addr), .wr_burst_len(wr_burst_len),
        .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data),
        .wr_burst_finish(wr_burst_finish), .rd_frame_base(rd_frame_base),
        .frame_done(frame_done), .fifo_ovf(fifo_ovf)
    );

    always #5 hdmi_clk = ~hdmi_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_q[$];
    bit          m_requesting = 0, m_transferring = 0, m_retiring = 0;
    bit          m_pend = 0, m_full = 0, m_sel = 0, m_ovf = 0, m_done = 0, m_vs_prev = 0;
    int unsigned m_offset = 0, m_popped = 0;
    logic [27:0] m_addr = BASE0, m_rd_base = BASE0;

    function automatic logic [27:0] frame_base(input bit sel);
        return sel ? BASE1 : BASE0;
    endfunction

    function automatic logic [27:0] byte_addr(input logic [27:0] base, input int unsigned words);
        logic [63:0] a;
        a = 64'(base) + 64'(words) * 64'd4;
        return a[27:0];
    endfunction

    always @(posedge hdmi_clk) begin : model_step
        int pre;
        bit accept, pop, rise, restart;
        if (sys_rst) begin
            m_q.delete();
            m_requesting = 0; m_transferring = 0; m_retiring = 0;
            m_pend = 0; m_full = 0; m_sel = 0; m_ovf = 0; m_done = 0; m_vs_prev = 0;
            m_offset = 0; m_popped = 0; m_addr = BASE0; m_rd_base = BASE0;
        end else begin
            pre     = m_q.size();
            accept  = hdmi_wr_en && pre < int'(DEPTH);
            pop     = wr_burst_data_req && (m_requesting || m_transferring)
                      && m_popped < BURST && pre > 0;
            rise    = hdmi_vs_in && !m_vs_prev;
            restart = 0;
            m_done  = 0;
            m_vs_prev = hdmi_vs_in;
            if (hdmi_wr_en && !accept) m_ovf = 1;

            if (m_retiring) begin
                m_offset += BURST;
                if (m_offset == FRAME) begin m_offset = 0; m_full = 1; end
                m_retiring = 0;
            end else if (m_transferring) begin
                if (wr_burst_finish) begin m_transferring = 0; m_retiring = 1; end
            end else if (m_requesting) begin
                if (wr_burst_data_req) begin m_requesting = 0; m_transferring = 1; end
            end else if (m_pend) begin
                restart  = 1;
                m_offset = 0;
                if (m_full) begin
                    m_done    = 1;
                    m_rd_base = frame_base(m_sel);
`ifdef FRAME_PINGPONG_EN
                    m_sel = !m_sel;
`endif
                end
                m_full = 0;
            end else if (pre >= int'(BURST)) begin
                m_requesting = 1;
                m_popped     = 0;
                m_addr       = byte_addr(frame_base(m_sel), m_offset);
            end
            m_pend = rise || (m_pend && !restart);

            if (pop) begin void'(m_q.pop_front()); m_popped++; end
            if (restart) m_q.delete();
            if (accept) m_q.push_back(hdmi_data_dw_in);
        end
    end

    always @(negedge hdmi_clk) begin
        #1;
        if (cmp_en) begin
            check("req", 64'(wr_burst_req), 64'(m_requesting));
            check("addr", 64'(wr_burst_addr), 64'(m_addr));
            check("len", 64'(wr_burst_len), 64'(BURST));
            check("rd_frame_base", 64'(rd_frame_base), 64'(m_rd_base));
            check("frame_done", 64'(frame_done), 64'(m_done));
            check("fifo_ovf", 64'(fifo_ovf), 64'(m_ovf));
            if (wr_burst_data_req && (m_requesting || m_transferring)
                && m_popped < BURST && m_q.size() > 0)
                check("data", 64'(wr_burst_data), 64'(m_q[0]));
            if (frame_done) done_cnt++;
        end
    end

    // ---------------- DDR write-port responder ----------------
    bit rst_q = 1'b1;
    bit ddr_auto = 1'b0, ddr_busy = 1'b0;
    int ddr_pops = 0, ddr_wait = 0, ddr_extra = 0, bursts_done = 0;

    always @(posedge hdmi_clk) rst_q <= sys_rst;

    always @(negedge hdmi_clk) begin
        wr_burst_data_req = 1'b0;
        wr_burst_finish   = 1'b0;
        if (rst_q || !ddr_auto) begin
            ddr_busy = 0;
            ddr_pops = 0;
        end else begin
            if (!ddr_busy && wr_burst_req) begin
                ddr_busy  = 1;
                ddr_pops  = 0;
                ddr_wait  = $urandom_range(0, 2);
                ddr_extra = ($urandom_range(0, 3) == 0) ? 2 : 0;
            end
            if (ddr_busy) begin
                if (ddr_wait > 0) begin
                    ddr_wait--;
                end else if (ddr_pops < int'(BURST) + ddr_extra) begin
                    if ($urandom_range(0, 3) != 0) begin
                        wr_burst_data_req = 1'b1;
                        ddr_pops++;
                    end
                end else begin
                    wr_burst_finish = 1'b1;
                    ddr_busy = 0;
                    bursts_done++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge hdmi_clk);
        #2;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge hdmi_clk);
            hdmi_wr_en      = 1'b1;
            hdmi_data_dw_in = $urandom;
        end
        @(negedge hdmi_clk);
        hdmi_wr_en = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int i;
        i = 0;
        tick();
        while (!wr_burst_req && i < 20) begin tick(); i++; end
        check({name, "_req"}, 64'(wr_burst_req), 64'd1);
    endtask

    task automatic wait_burst(input string name);
        int i, target;
        i = 0;
        target = bursts_done + 1;
        while (bursts_done < target && i < 400) begin tick(); i++; end
        check({name, "_burst_done"}, 64'(bursts_done >= target), 64'd1);
        repeat (4) tick();
    endtask

    task automatic pulse_reset();
        @(negedge hdmi_clk);
        sys_rst = 1'b1;
        @(negedge hdmi_clk);
        sys_rst = 1'b0;
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int i, done_before, vs_cnt;
        sys_rst = 1'b1; hdmi_vs_in = 1'b0; hdmi_wr_en = 1'b0; hdmi_data_dw_in = '0;
        repeat (3) @(negedge hdmi_clk);
        sys_rst = 1'b0;
        cmp_en  = 1'b1;
        tick();
        check("rst_req", 64'(wr_burst_req), 64'd0);
        check("rst_addr", 64'(wr_burst_addr), 64'(BASE0));
        check("rst_rd_base", 64'(rd_frame_base), 64'(BASE0));
        check("rst_done", 64'(frame_done), 64'd0);
        check("rst_ovf", 64'(fifo_ovf), 64'd0);

        // First burst at offset 0, second at 0x100; two bursts fill the 128-word frame.
        push_words(64);
        wait_req("t1a");
        check("t1a_addr", 64'(wr_burst_addr), 64'h0);
        ddr_auto = 1'b1;
        wait_burst("t1a");
        push_words(64);
        wait_req("t1b");
        check("t1b_addr", 64'(wr_burst_addr), 64'h100);
        wait_burst("t1b");

        // VSYNC after a full frame publishes it and moves the write buffer.
        @(negedge hdmi_clk);
        hdmi_vs_in = 1'b1;
        i = 0;
        tick();
        while (!frame_done && i < 10) begin tick(); i++; end
        check("t3_done", 64'(frame_done), 64'd1);
        check("t3_rd_base", 64'(rd_frame_base), 64'(BASE0));
        tick();
        check("t3_done_pulse", 64'(frame_done), 64'd0);
        @(negedge hdmi_clk);
        hdmi_vs_in = 1'b0;
        push_words(64);
        wait_req("t3");
        check("t3_addr", 64'(wr_burst_addr), 64'(SWAP_BASE));
        wait_burst("t3");

        // Overflow: 256 words fit, the 257th is dropped and the flag sticks.
        ddr_auto = 1'b0;
        push_words(256);
        tick();
        check("t2_ovf_at_full", 64'(fifo_ovf), 64'd0);
        push_words(1);
        tick();
        check("t2_ovf_set", 64'(fifo_ovf), 64'd1);
        repeat (5) tick();
        check("t2_ovf_sticky", 64'(fifo_ovf), 64'd1);
        ddr_auto = 1'b1;
        for (int b = 0; b < 4; b++) wait_burst("t2_drain");
        repeat (10) tick();
        check("t2_drained", 64'(wr_burst_req), 64'd0);
        check("t2_ovf_kept", 64'(fifo_ovf), 64'd1);
        pulse_reset();
        check("t2_ovf_cleared", 64'(fifo_ovf), 64'd0);

        // VSYNC mid-burst: burst completes, then remainder flushed and offset restarts.
        ddr_auto = 1'b0;
        push_words(84);
        wait_req("t4a");
        ddr_auto = 1'b1;
        i = 0;
        while (ddr_pops < 40 && i < 200) begin tick(); i++; end
        check("t4_mid_burst", 64'(ddr_pops >= 40), 64'd1);
        done_before = done_cnt;
        @(negedge hdmi_clk);
        hdmi_vs_in = 1'b1;
        repeat (3) @(negedge hdmi_clk);
        hdmi_vs_in = 1'b0;
        wait_burst("t4a");
        check("t4_no_frame_done", 64'(done_cnt), 64'(done_before));
        push_words(44);
        repeat (5) tick();
        check("t4_flushed", 64'(wr_burst_req), 64'd0);
        push_words(20);
        wait_req("t4b");
        check("t4_addr", 64'(wr_burst_addr), 64'(BASE0));
        wait_burst("t4b");

        // Partial frame then VSYNC: nothing requested, FIFO empty, next burst at base.
        push_words(30);
        @(negedge hdmi_clk);
        hdmi_vs_in = 1'b1;
        repeat (3) @(negedge hdmi_clk);
        hdmi_vs_in = 1'b0;
        repeat (4) tick();
        check("t5_noreq", 64'(wr_burst_req), 64'd0);
        push_words(34);
        repeat (5) tick();
        check("t5_flushed", 64'(wr_burst_req), 64'd0);
        push_words(30);
        wait_req("t5");
        check("t5_addr", 64'(wr_burst_addr), 64'(BASE0));

        // Reset during DATA aborts the burst and empties the FIFO.
        i = 0;
        while (ddr_pops < 10 && i < 200) begin tick(); i++; end
        check("t6_in_data", 64'(ddr_pops >= 10), 64'd1);
        pulse_reset();
        check("t6_req", 64'(wr_burst_req), 64'd0);
        check("t6_ovf", 64'(fifo_ovf), 64'd0);
        check("t6_addr", 64'(wr_burst_addr), 64'(BASE0));
        push_words(63);
        repeat (5) tick();
        check("t6_level_zero", 64'(wr_burst_req), 64'd0);
        push_words(1);
        wait_req("t6");
        check("t6_addr_after", 64'(wr_burst_addr), 64'(BASE0));
        wait_burst("t6");

        // Randomized traffic: writes, VSYNC pulses and occasional resets.
        vs_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge hdmi_clk);
            hdmi_wr_en      = ($urandom_range(0, 9) < 6);
            hdmi_data_dw_in = $urandom;
            sys_rst         = ($urandom_range(0, 1499) == 0);
            if (vs_cnt > 0) begin
                vs_cnt--;
                hdmi_vs_in = 1'b1;
            end else begin
                hdmi_vs_in = 1'b0;
                if ($urandom_range(0, 249) == 0) vs_cnt = $urandom_range(1, 4);
            end
        end
        @(negedge hdmi_clk);
        hdmi_wr_en = 1'b0;
        hdmi_vs_in = 1'b0;
        sys_rst    = 1'b0;
        repeat (300) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
